// File: rtl/ln_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ln_request_sequencer
// Purpose  : Sequences single-precision ln() requests onto a CORDIC log core.
//            Special operands (zero/denormal, negative, inf, NaN, 1.0) are
//            answered directly; all others are issued to the core with a
//            one-cycle start pulse, and the answer is captured on the first
//            core acknowledge or replaced by a quiet NaN on timeout.
// Ports    : clk, rst                     clock / synchronous active-high reset
//            in_valid, in_ready, in_t     operand handshake and argument
//            ln_rst, ln_begin, ln_t       core reset, start and argument
//            ln_ack, ln_result, ln_of/uf  core completion, result and flags
//            out_valid, out_ready         result handshake
//            out_result, out_of/uf/nv/to  result and status flags
//            busy                         high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module ln_request_sequencer #(
  parameter int P      = 32,   // only IEEE-754 single (32) is supported
  parameter int TO_CYC = 255   // WAIT-cycle limit, legal range 2..255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_t,
  output logic         ln_rst,
  output logic         ln_begin,
  output logic [P-1:0] ln_t,
  input  logic         ln_ack,
  input  logic [P-1:0] ln_result,
  input  logic         ln_of,
  input  logic         ln_uf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_result,
  output logic         out_of,
  output logic         out_uf,
  output logic         out_nv,
  output logic         out_to,
  output logic         busy
);

  localparam logic [P-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [P-1:0] NEG_INF = 32'hFF80_0000;
  localparam logic [P-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [P-1:0] ONE     = 32'h3F80_0000;
  localparam logic [7:0]   TO_LAST = 8'(TO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [7:0]   to_cnt;

  logic         accept;
  logic         timeout;
  logic [7:0]   t_exp;
  logic         t_man_nz;
  logic         sp_hit;
  logic [P-1:0] sp_result;
  logic         sp_nv;

  assign accept   = in_valid && (state == S_IDLE);
  assign timeout  = (to_cnt == TO_LAST);
  assign t_exp    = in_t[30:23];
  assign t_man_nz = |in_t[22:0];

  // Special-operand decode. NaN is tested first so a negative NaN reports
  // as NaN; zero/denormal precede the sign test so -0 and negative
  // denormals give -inf rather than an invalid-operand NaN.
  always_comb begin
    sp_hit    = 1'b1;
    sp_result = '0;
    sp_nv     = 1'b0;
    if (t_exp == 8'hFF && t_man_nz) begin
      sp_result = QNAN;
      sp_nv     = 1'b1;
    end else if (t_exp == 8'h00) begin
      sp_result = NEG_INF;
    end else if (in_t[31]) begin
      sp_result = QNAN;
      sp_nv     = 1'b1;
    end else if (t_exp == 8'hFF) begin
      sp_result = POS_INF;
    end else if (in_t == ONE) begin
      sp_result = '0;
    end else begin
      sp_hit    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ln_begin  = 1'b0;
    ln_rst    = rst;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        ln_rst   = 1'b1;
        busy     = 1'b0;
        if (accept) begin
          state_nxt = sp_hit ? S_DONE : S_START;
        end
      end
      S_START: begin
        ln_begin  = !rst;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (ln_ack || timeout) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ln_rst    = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand, timeout counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ln_t       <= '0;
      to_cnt     <= '0;
      out_result <= '0;
      out_of     <= 1'b0;
      out_uf     <= 1'b0;
      out_nv     <= 1'b0;
      out_to     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            ln_t <= in_t;
            if (sp_hit) begin
              out_result <= sp_result;
              out_nv     <= sp_nv;
              out_of     <= 1'b0;
              out_uf     <= 1'b0;
              out_to     <= 1'b0;
            end
          end
        end
        S_START: begin
          to_cnt <= '0;
        end
        S_WAIT: begin
          // Acknowledge in the threshold cycle takes priority over timeout.
          if (ln_ack) begin
            out_result <= ln_result;
            out_of     <= ln_of;
            out_uf     <= ln_uf;
            out_nv     <= 1'b0;
            out_to     <= 1'b0;
          end else if (timeout) begin
            out_result <= QNAN;
            out_of     <= 1'b0;
            out_uf     <= 1'b0;
            out_nv     <= 1'b0;
            out_to     <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ln_request_sequencer.md
LN_REQUEST_SEQUENCER -- requirements
Module: ln_request_sequencer

Interface
REQ-001 Parameter P, default 32: operand/result width; only 32 (IEEE-754 single) is supported.
REQ-002 Parameter TO_CYC, default 255: maximum WAIT cycles before timeout; legal range 2..255.
REQ-003 The block SHALL have one clock, CLK, and one reset, RST, which is synchronous and active-high.
REQ-004 CLK  in  1  system clock; all state changes on the rising edge.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 IN_VALID  in  1  operand offered.
REQ-007 IN_READY  out  1  block can accept an operand.
REQ-008 IN_T  in  P  log argument, IEEE single.
REQ-009 LN_RST  out  1  drives the CORDIC core reset (RST_LN).
REQ-010 LN_BEGIN  out  1  drives the core start (Begin_FSM_LN).
REQ-011 LN_T  out  P  drives the core argument T.
REQ-012 LN_ACK  in  1  core done, level.
REQ-013 LN_RESULT  in  P  core result.
REQ-014 LN_OF, LN_UF  in  1 each  core overflow/underflow flags.
REQ-015 OUT_VALID  out  1  result available.
REQ-016 OUT_READY  in  1  consumer takes result.
REQ-017 OUT_RESULT  out  P  ln(IN_T).
REQ-018 OUT_OF, OUT_UF, OUT_NV, OUT_TO  out  1 each  overflow, underflow, invalid operand, core timeout.
REQ-019 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, START, WAIT, DONE.
REQ-021 IN_READY SHALL be 1 only in IDLE; an operand is accepted on IN_VALID&IN_READY.
REQ-022 On acceptance, LN_T SHALL register IN_T and hold it until the next acceptance.
REQ-023 Accepted special operands SHALL bypass the core: IDLE->DONE with OUT_VALID=1 in the next cycle.
- sign=1, nonzero, non-NaN: 0x7FC00000, NV=1.
- Zero or denormal, either sign: 0xFF800000.
- +inf: 0x7F800000.
- Any NaN: 0x7FC00000, NV=1.
- 0x3F800000 (1.0): 0x00000000.
REQ-024 Other accepted operands SHALL go IDLE->START; START lasts exactly one cycle with LN_BEGIN=1, then goes to WAIT.
REQ-025 LN_RST SHALL be 1 in IDLE and DONE and while RST=1, and 0 in START and WAIT.
REQ-026 LN_BEGIN SHALL be 0 in every state other than START.
REQ-027 In WAIT, the first cycle with LN_ACK=1 SHALL capture LN_RESULT, LN_OF and LN_UF into OUT_RESULT, OUT_OF and OUT_UF and go to DONE; NV=0 and TO=0.
REQ-028 Timeout counter (8 bit) SHALL clear on entry to WAIT and increment each WAIT cycle with LN_ACK=0.
- At count TO_CYC-1 with LN_ACK=0, the FSM goes to DONE with OUT_RESULT=0x7FC00000, OUT_TO=1, other flags 0.
- LN_ACK in the threshold cycle wins over timeout.
REQ-029 DONE SHALL hold OUT_VALID=1 with stable OUT_* until OUT_READY=1, then go to IDLE; OUT_VALID=0 in all other states.
REQ-030 Timing:
- Core path: acceptance at cycle n, LN_BEGIN at n+1, WAIT from n+2, LN_ACK at cycle m gives OUT_VALID at m+1.
- The minimum bubble between handshakes is one IDLE cycle.
REQ-031 LN_ACK, LN_RESULT and the core flags SHALL be ignored outside WAIT.
REQ-032 IN_VALID while not IDLE SHALL have no effect; the operand is not accepted.

Reset
REQ-033 RST=1 at any cycle, including mid-WAIT or DONE, SHALL force the following on the next edge:
- state IDLE, counter 0;
- OUT_VALID=0, OUT_RESULT=0, all OUT flags=0;
- LN_T=0, LN_BEGIN=0, LN_RST=1;
- BUSY=0.
IN_READY SHALL be 1 from the first cycle after RST deasserts.
REQ-034 An in-flight core result SHALL be discarded on reset; an LN_ACK arriving after reset SHALL be ignored.

Verification
REQ-035 IN_T=0x40000000 accepted at cycle 0 -> LN_BEGIN=1 at cycle 1. LN_ACK at cycle 20 with LN_RESULT=0x3F317218 -> OUT_VALID at cycle 21 with OUT_RESULT=0x3F317218, flags 0.
REQ-036 Special operands -> bypass with OUT_VALID one cycle after accept and LN_BEGIN never asserted:
- 0xBF800000 -> 0x7FC00000, NV=1.
- 0x00000000 -> 0xFF800000.
- 0x3F800000 -> 0x00000000.
- 0x7F800000 -> 0x7F800000.
REQ-037 TO_CYC=8, LN_ACK held 0 -> DONE after 8 WAIT cycles with 0x7FC00000 and OUT_TO=1; repeating with LN_ACK asserted on the 8th WAIT cycle -> normal capture and OUT_TO=0.
REQ-038 OUT_READY=0 for 10 cycles in DONE -> OUT_* stable and IN_READY=0; IN_VALID pulsed meanwhile is not accepted.
REQ-039 RST=1 during WAIT, then LN_ACK=1 the next cycle -> OUT_VALID stays 0, LN_RST=1, IN_READY=1 after RST deasserts.
